bcd_to_bin: RTL and testbench

Sequential 4-digit packed-BCD to binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from each BCD nibble that is >= 8. Sits between the keypad/setpoint entry logic, which holds values as BCD digits, and the datapath, which compares and scales in binary. Uses a start/busy/done handshake and flags any non-decimal nibble as an error instead of converting it.

---
 rtl/bcd_to_bin.sv | 116 +++++++++++
 tb/tb_bcd_to_bin.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One right shift plus per-digit correction per cycle; non-decimal digits are reported as an error.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SW    = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SW-1:0]      scratch_reg, scratch_next;
    logic [BIN_W-1:0]   bin_out_reg, bin_out_next;
    logic               done_reg, done_next;
    logic               error_reg, error_next;

    logic [SW-1:0]      shifted;
    logic [BCD_W-1:0]   corr_bcd;
    logic [SW-1:0]      corrected;
    logic [DIGITS-1:0]  nib_bad;
    logic               last_shift;

    assign shifted = scratch_reg >> 1;

    // A digit that picked up the halved weight of its upper neighbour reads as >= 8
    // and must drop by 3 to stay a valid decimal digit after the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib                 = shifted[BIN_W + gi*4 +: 4];
            assign corr_bcd[gi*4 +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
            assign nib_bad[gi]         = (bcd_in[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    assign corrected  = {corr_bcd, shifted[BIN_W-1:0]};
    assign last_shift = (cnt_reg == CNT_W'(BIN_W - 1));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        scratch_next = scratch_reg;
        bin_out_next = bin_out_reg;
        done_next    = 1'b0;
        error_next   = error_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    error_next = 1'b0;
                    if (|nib_bad) begin
                        done_next  = 1'b1;
                        error_next = 1'b1;
                    end else begin
                        scratch_next = {bcd_in, {BIN_W{1'b0}}};
                        cnt_next     = '0;
                        state_next   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                scratch_next = corrected;
                cnt_next     = cnt_reg + 1'b1;
                if (last_shift) begin
                    bin_out_next = corrected[BIN_W-1:0];
                    state_next   = IDLE;
                    done_next    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            scratch_reg <= '0;
            bin_out_reg <= '0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            scratch_reg <= scratch_next;
            bin_out_reg <= bin_out_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
        end
    end

    // Every decimal digit must have been fully shifted out by the final iteration.
    always_ff @(posedge clk) begin
        if (!reset && state_reg == SHIFT && last_shift)
            assert (corrected[SW-1:BIN_W] == '0);
    end

    assign bin_out = bin_out_reg;
    assign busy    = (state_reg == SHIFT);
    assign done    = done_reg;
    assign error   = error_reg;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: stimulus pushes expected results, a monitor
// pops and checks value, error flag and latency on every done pulse.
module tb_bcd_to_bin;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [15:0] bin_out;
    logic        busy, done, error;

    bcd_to_bin #(.DIGITS(4), .BIN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
        .bin_out(bin_out), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   cycle_cnt = 0;
    int   done_cnt = 0;

    always @(posedge clk) cycle_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Monitor: latency counts the accepting edge's cycle as 1 (17 success, 1 error).
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = q.pop_front();
                chk("bin_out", 32'(bin_out), 32'(e.bin));
                chk("error", 32'(error), 32'(e.err));
                chk("latency", 32'(cycle_cnt - e.acc + 1), e.err ? 32'd1 : 32'd17);
                $display("txn bin_out=%04h error=%0d latency=%0d", bin_out, error, cycle_cnt - e.acc + 1);
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns just after the accepting edge.
    task automatic issue(input logic [15:0] bcd, input logic [15:0] exp_bin, input logic exp_err);
        exp_t e;
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        e.bin = exp_bin;
        e.err = exp_err;
        e.acc = cycle_cnt;
        q.push_back(e);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high, so a following issue lands on the done cycle.
    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        int dc0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Maximum input, busy duration
        issue(16'h9999, 16'h270F, 1'b0);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) break;
        end
        chk("busy_cycles", 32'(bcnt), 32'd16);
        chk("busy_at_done", 32'(busy), 32'd0);

        // Back-to-back, second start on the done cycle
        @(negedge clk);
        issue(16'h1234, 16'h04D2, 1'b0);
        wait_done();
        issue(16'h0000, 16'h0000, 1'b0);
        wait_done();

        // Error request holds bin_out, then a valid request clears error
        issue(16'h1234, 16'h04D2, 1'b0);
        wait_done();
        @(negedge clk);
        issue(16'h12A4, 16'h04D2, 1'b1);
        @(negedge clk);
        chk("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_held", 32'(error), 32'd1);
        chk("err_done_low", 32'(done), 32'd0);
        chk("err_bin_held", 32'(bin_out), 32'h04D2);
        issue(16'h0042, 16'h002A, 1'b0);
        @(negedge clk);
        chk("err_cleared", 32'(error), 32'd0);
        wait_done();

        // start and bcd_in toggled mid-conversion are ignored
        @(negedge clk);
        dc0 = done_cnt;
        issue(16'h0500, 16'h01F4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start  = 1'b1;
            bcd_in = i[0] ? 16'h9999 : 16'h1111;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("single_done", 32'(done_cnt - dc0), 32'd1);

        // Reset mid-conversion aborts
        issue(16'h0777, 16'h0309, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        dc0 = done_cnt;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bin_out", 32'(bin_out), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        issue(16'h0001, 16'h0001, 1'b0);
        wait_done();

        // Strided sweep of decimal values plus the top end, back-to-back
        @(negedge clk);
        for (int v = 0; v < 10000; v += 13) begin
            issue(to_bcd(v), 16'(v), 1'b0);
            wait_done();
        end
        issue(16'h9998, 16'd9998, 1'b0);
        wait_done();
        issue(16'h9999, 16'd9999, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
